// File: rtl/axis_matvec_tiled_pkg.sv
// Shared types and helpers for the tiled matrix-vector multiplier.
package matvec_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_e;

  // Width of one exact signed dot product over c terms.
  function automatic int unsigned w_y(input int unsigned w_x, input int unsigned w_k,
                                      input int unsigned c);
    return w_x + w_k + $clog2(c);
  endfunction

  // Bit offset of the first element of a matrix row (row-major, row 0 at LSB).
  function automatic int unsigned row_lsb(input int unsigned row, input int unsigned c,
                                          input int unsigned w_k);
    return row * c * w_k;
  endfunction

  // Bit offset of element idx in a packed vector of w-bit elements.
  function automatic int unsigned elem_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/axis_matvec_tiled_if.sv
// Single-beat valid/ready stream bundle.
interface axis_matvec_tiled_if #(
  parameter int unsigned DW = 8
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/axis_matvec_tiled_dot_product.sv
// Combinational signed dot product: C parallel multiplies into a balanced adder tree.
module dot_product
  import matvec_pkg::*;
#(
  parameter int unsigned C   = 8,
  parameter int unsigned W_X = 8,
  parameter int unsigned W_K = 8,
  localparam int unsigned W_Y = w_y(W_X, W_K, C)
) (
  input  logic [C*W_K-1:0]      k_row_i,
  input  logic [C*W_X-1:0]      x_i,
  output logic signed [W_Y-1:0] y_o
);
  localparam int unsigned LV = $clog2(C);
  localparam int unsigned N  = 1 << LV;

  // Level 0 holds sign-extended products (zero-padded to a power of two);
  // each further level halves the node count.
  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    logic signed [W_Y-1:0] s [N>>l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_i
        if (i < C) begin : g_prod
          logic signed [W_K-1:0]     k_e;
          logic signed [W_X-1:0]     x_e;
          logic signed [W_X+W_K-1:0] prod;
          assign k_e  = k_row_i[elem_lsb(i, W_K) +: W_K];
          assign x_e  = x_i[elem_lsb(i, W_X) +: W_X];
          assign prod = k_e * x_e;
          assign s[i] = W_Y'(prod);
        end else begin : g_pad
          assign s[i] = '0;
        end
      end
    end else begin : g_add
      for (genvar i = 0; i < (N >> l); i++) begin : g_i
        assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
      end
    end
  end

  assign y_o = g_lvl[LV].s[0];

endmodule

// File: rtl/axis_matvec_tiled.sv
// Tiled signed matrix-vector multiplier y = K*x, P rows per cycle over R/P cycles.
// Optional build macro AXIS_MATVEC_RELU_EN clamps negative y elements to 0.
module axis_matvec_tiled
  import matvec_pkg::*;
#(
  parameter int unsigned R   = 8,
  parameter int unsigned C   = 8,
  parameter int unsigned W_X = 8,
  parameter int unsigned W_K = 8,
  parameter int unsigned P   = 2
) (
  input logic               clk,
  input logic               rstn,
  axis_matvec_tiled_if.slave  s,
  axis_matvec_tiled_if.master m
);
  localparam int unsigned T   = R / P;
  localparam int unsigned W_Y = w_y(W_X, W_K, C);
  localparam int unsigned TW  = (T > 1) ? $clog2(T) : 1;
  localparam int unsigned KW  = R * C * W_K;
  localparam int unsigned XW  = C * W_X;

  if (P == 0 || (R % P) != 0) begin : g_bad_p
    $error("axis_matvec_tiled: P must divide R");
  end

  state_e             state_q;
  logic [TW-1:0]      t_q;
  logic [KW-1:0]      k_q;
  logic [XW-1:0]      x_q;
  logic [R*W_Y-1:0]   y_q;
  logic               m_valid_q;
  logic [P*W_Y-1:0]   tile_y_d;
  logic               accept;

  assign s.ready = (state_q == IDLE) || (state_q == HOLD && m.ready);
  assign accept  = s.valid && s.ready;
  assign m.valid = m_valid_q;
  assign m.data  = y_q;

  // One lane per row of the current tile; row select is muxed from the operand register.
  for (genvar p = 0; p < P; p++) begin : g_lane
    logic [C*W_K-1:0]      k_row;
    logic signed [W_Y-1:0] dot;

    assign k_row = k_q[row_lsb(32'(t_q) * P + p, C, W_K) +: C*W_K];

    dot_product #(.C(C), .W_X(W_X), .W_K(W_K)) u_dot (
      .k_row_i (k_row),
      .x_i     (x_q),
      .y_o     (dot)
    );

`ifdef AXIS_MATVEC_RELU_EN
    assign tile_y_d[p*W_Y +: W_Y] = dot[W_Y-1] ? '0 : dot;
`else
    assign tile_y_d[p*W_Y +: W_Y] = dot;
`endif
  end

  // Control FSM with operand latch, tile write-back and registered m_valid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      t_q       <= '0;
      k_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      m_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            k_q     <= s.data[XW +: KW];
            x_q     <= s.data[XW-1:0];
            t_q     <= '0;
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          y_q[32'(t_q) * P * W_Y +: P*W_Y] <= tile_y_d;
          t_q <= t_q + 1'b1;
          if (t_q == TW'(T - 1)) begin
            state_q   <= HOLD;
            m_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (m.ready) begin
            m_valid_q <= 1'b0;
            // Back-to-back accept skips the IDLE bubble.
            if (accept) begin
              k_q     <= s.data[XW +: KW];
              x_q     <= s.data[XW-1:0];
              t_q     <= '0;
              state_q <= COMPUTE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_matvec_tiled.sv
// Scoreboard bench for axis_matvec_tiled: P=2 instance (directed + random) and P=R instance.
module tb_axis_matvec_tiled;
  localparam int R   = 8;
  localparam int C   = 8;
  localparam int W_X = 8;
  localparam int W_K = 8;
  localparam int P   = 2;
  localparam int T   = R / P;
  localparam int W_Y = W_X + W_K + $clog2(C);
  localparam int DIN = R*C*W_K + C*W_X;
  localparam int YW  = R * W_Y;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  axis_matvec_tiled_if #(.DW(DIN)) s_if ();
  axis_matvec_tiled_if #(.DW(YW))  m_if ();
  axis_matvec_tiled_if #(.DW(DIN)) s8_if ();
  axis_matvec_tiled_if #(.DW(YW))  m8_if ();

  axis_matvec_tiled #(.R(R), .C(C), .W_X(W_X), .W_K(W_K), .P(P)) dut (
    .clk(clk), .rstn(rstn), .s(s_if), .m(m_if)
  );

  axis_matvec_tiled #(.R(R), .C(C), .W_X(W_X), .W_K(W_K), .P(R)) dut8 (
    .clk(clk), .rstn(rstn), .s(s8_if), .m(m8_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [YW-1:0] exp_q  [$];
  logic [YW-1:0] exp8_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer dot products from the packed {K, x} beat.
  function automatic logic [YW-1:0] model(input logic [DIN-1:0] d);
    logic [YW-1:0] y;
    longint acc;
    logic signed [W_K-1:0] k;
    logic signed [W_X-1:0] xe;
    y = '0;
    for (int r = 0; r < R; r++) begin
      acc = 0;
      for (int c = 0; c < C; c++) begin
        k  = d[C*W_X + (r*C + c)*W_K +: W_K];
        xe = d[c*W_X +: W_X];
        acc += longint'(k) * longint'(xe);
      end
`ifdef AXIS_MATVEC_RELU_EN
      if (acc < 0) acc = 0;
`endif
      y[r*W_Y +: W_Y] = acc[W_Y-1:0];
    end
    return y;
  endfunction

  function automatic logic [DIN-1:0] pack(input int km [R][C], input int xv [C]);
    logic [DIN-1:0] d;
    logic [31:0] v;
    d = '0;
    for (int c = 0; c < C; c++) begin
      v = xv[c];
      d[c*W_X +: W_X] = v[W_X-1:0];
    end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        v = km[r][c];
        d[C*W_X + (r*C + c)*W_K +: W_K] = v[W_K-1:0];
      end
    return d;
  endfunction

  function automatic logic [DIN-1:0] rand_beat();
    logic [DIN-1:0] d;
    for (int i = 0; i < DIN; i++) d[i] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  function automatic longint y_elem(input logic [YW-1:0] y, input int r);
    logic signed [W_Y-1:0] e;
    e = y[r*W_Y +: W_Y];
    return longint'(e);
  endfunction

  function automatic longint relu(input longint v);
`ifdef AXIS_MATVEC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Output monitors: compare every delivered beat against the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn && m_if.valid && m_if.ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL p2_unexpected_beat: got %h expected none", m_if.data);
      end else begin
        logic [YW-1:0] e;
        e = exp_q.pop_front();
        if (m_if.data !== e) begin
          n_err++;
          $display("FAIL p2_y: got %h expected %h", m_if.data, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && m8_if.valid && m8_if.ready) begin
      n_vec++;
      if (exp8_q.size() == 0) begin
        n_err++;
        $display("FAIL p8_unexpected_beat: got %h expected none", m8_if.data);
      end else begin
        logic [YW-1:0] e;
        e = exp8_q.pop_front();
        if (m8_if.data !== e) begin
          n_err++;
          $display("FAIL p8_y: got %h expected %h", m8_if.data, e);
        end
      end
    end
  end

  // Issue one beat to the P=2 DUT; returns the cycle stamp of its accept.
  task automatic send(input logic [DIN-1:0] d, input bit rand_rdy, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    s_if.valid = 1'b1;
    s_if.data  = d;
    forever begin
      @(negedge clk);
      if (s_if.ready) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        s_if.valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (rand_rdy) m_if.ready = 1'($urandom_range(0, 1));
    end
    exp_q.push_back(model(d));
    acc_cyc = cyc;
    @(posedge clk); #1;
    s_if.valid = 1'b0;
    s_if.data  = rand_beat();
  endtask

  task automatic send8(input logic [DIN-1:0] d);
    int n;
    n = 0;
    s8_if.valid = 1'b1;
    s8_if.data  = d;
    forever begin
      @(negedge clk);
      if (s8_if.ready) break;
      n++;
      if (n > 200) begin
        chk("send8_timeout", 0, 1);
        s8_if.valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    exp8_q.push_back(model(d));
    @(posedge clk); #1;
    s8_if.valid = 1'b0;
    s8_if.data  = rand_beat();
  endtask

  // Counts cycles after an accept until m_valid; s_ready must stay low meanwhile.
  task automatic wait_valid(output int n);
    n = 0;
    while (!m_if.valid && n < 50) begin
      chk("compute_s_ready", longint'(s_if.ready), 0);
      @(posedge clk); #1;
      n++;
    end
  endtask

  int km [R][C];
  int xv [C];
  int lat, a0, a1, a2, nd;
  logic [YW-1:0] held;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    s_if.valid = 1'b0;  s_if.data = '0;  m_if.ready = 1'b0;
    s8_if.valid = 1'b0; s8_if.data = '0; m8_if.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_m_valid", longint'(m_if.valid), 0);
    chk("reset_s_ready", longint'(s_if.ready), 1);
    chk("reset_m_data_zero", longint'(m_if.data == '0), 1);
    rstn = 1'b1;

    // Identity matrix with alternating-sign x.
    m_if.ready = 1'b1;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) km[r][c] = (r == c) ? 1 : 0;
    for (int c = 0; c < C; c++) xv[c] = (c % 2 == 0) ? (c + 1) : -(c + 1);
    send(pack(km, xv), 1'b0, a0);
    wait_valid(lat);
    chk("identity_latency", lat, T);
    for (int i = 0; i < R; i++) chk($sformatf("identity_y%0d", i), y_elem(m_if.data, i), relu(xv[i]));
    @(posedge clk); #1;
    chk("identity_single_beat", longint'(m_if.valid), 0);

    // Extremes.
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) km[r][c] = -128;
    for (int c = 0; c < C; c++) xv[c] = -128;
    send(pack(km, xv), 1'b0, a0);
    wait_valid(lat);
    for (int i = 0; i < R; i++) chk($sformatf("ext_neg_y%0d", i), y_elem(m_if.data, i), 131072);
    for (int c = 0; c < C; c++) xv[c] = 127;
    send(pack(km, xv), 1'b0, a0);
    wait_valid(lat);
    for (int i = 0; i < R; i++) chk($sformatf("ext_pos_y%0d", i), y_elem(m_if.data, i), relu(-130048));

    // Backpressure.
    @(posedge clk); #1;
    m_if.ready = 1'b0;
    send(rand_beat(), 1'b0, a0);
    wait_valid(lat);
    chk("bp_latency", lat, T);
    held = m_if.data;
    for (int i = 0; i < 10; i++) begin
      chk("bp_m_valid", longint'(m_if.valid), 1);
      chk("bp_s_ready", longint'(s_if.ready), 0);
      chk("bp_data_stable", longint'(m_if.data == held), 1);
      @(posedge clk); #1;
    end
    m_if.ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_consumed_once", longint'(m_if.valid), 0);

    // Back-to-back with m_ready high.
    send(rand_beat(), 1'b0, a0);
    send(rand_beat(), 1'b0, a1);
    send(rand_beat(), 1'b0, a2);
    chk("b2b_period_1", a1 - a0, T + 1);
    chk("b2b_period_2", a2 - a1, T + 1);
    nd = 0;
    while (exp_q.size() > 0 && nd < 100) begin @(posedge clk); nd++; end
    #1;
    chk("b2b_drained", exp_q.size(), 0);

    // Reset during COMPUTE at t=2 drops the beat.
    @(posedge clk); #1;
    send(rand_beat(), 1'b0, a0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_q.delete();
    chk("midrst_m_valid", longint'(m_if.valid), 0);
    chk("midrst_s_ready", longint'(s_if.ready), 1);
    chk("midrst_m_data_zero", longint'(m_if.data == '0), 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_stale", longint'(m_if.valid), 0);
    end

    // Random beats with random gaps and random backpressure.
    for (int b = 0; b < 20; b++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        m_if.ready = 1'($urandom_range(0, 1));
      end
      send(rand_beat(), 1'b1, a0);
    end
    m_if.ready = 1'b1;
    nd = 0;
    while (exp_q.size() > 0 && nd < 200) begin @(posedge clk); nd++; end
    #1;
    chk("rand_drained", exp_q.size(), 0);

    // P=R instance: single-cycle COMPUTE.
    m8_if.ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      send8(rand_beat());
      chk("p8_compute_s_ready", longint'(s8_if.ready), 0);
      @(posedge clk); #1;
      chk("p8_latency", longint'(m8_if.valid), 1);
    end
    nd = 0;
    while (exp8_q.size() > 0 && nd < 50) begin @(posedge clk); nd++; end
    #1;
    chk("p8_drained", exp8_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
